// File: rtl/rfPhoenixPkg.sv
// Shared instruction-word types for the rfPhoenix front end, plus the
// NOP filler inserted as the prefix slot when no PFX word precedes an instruction.
package rfPhoenixPkg;

    typedef logic [5:0] opcode_t;

    localparam opcode_t NOP  = 6'h00;
    localparam opcode_t ADDI = 6'h04;
    localparam opcode_t ORI  = 6'h09;
    localparam opcode_t PFX  = 6'h3F;

    typedef struct packed {
        logic [15:0] imm;
        logic [4:0]  rb;
        logic [4:0]  rt;
        opcode_t     opcode;
    } Instruction;

    typedef struct packed {
        logic [31:0] pc;
        Instruction  pfx;
        Instruction  insn;
    } InstructionFetchbuf;

    localparam Instruction NOP_INSN = '{imm: 16'h0000, rb: 5'd0, rt: 5'd0, opcode: NOP};

endpackage

// File: rtl/rfphoenix_ifb_fifo.sv
// DEPTH-entry synchronous FIFO of fetch-buffer entries with flush; 1-cycle write-to-read latency.
// Caller must not write when full; reads on an empty FIFO are ignored; flush beats both.
module rfphoenix_ifb_fifo
    import rfPhoenixPkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  InstructionFetchbuf       wr_dat,
    input  logic                     rd_en,
    output InstructionFetchbuf       rd_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]      head;
    logic [AW-1:0]      tail;
    logic [AW:0]        cnt;
    InstructionFetchbuf mem [DEPTH];
    logic               rd_ok;

    assign rd_ok  = rd_en && (cnt != '0);
    assign rd_dat = mem[head];
    assign count  = cnt;

    // Storage is reset so the head slot never shows X while the FIFO is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (wr_en) begin
                mem[tail] <= wr_dat;
                tail      <= tail + AW'(1);
            end
            if (rd_ok) begin
                head <= head + AW'(1);
            end
            case ({wr_en, rd_ok})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/rfphoenix_ifb_queue.sv
// Fetch buffer: folds PFX words into their successor and queues entries for decode.
// Latency 1 cycle accept-to-out_valid; in_ready drops only when the queue is full, flush discards all.
module rfphoenix_ifb_queue
    import rfPhoenixPkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  Instruction               in_insn,
    output logic                     out_valid,
    input  logic                     out_ready,
    output InstructionFetchbuf       out_ifb,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic               pfx_valid;
    Instruction         pfx_word;
    logic [31:0]        pfx_pc;
    logic               accept;
    logic               is_pfx;
    logic               enq;
    logic               deq;
    InstructionFetchbuf merged;

    assign in_ready  = (count < DEPTH_C);
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready && !flush;
    assign is_pfx    = (in_insn.opcode == PFX);
    assign enq       = accept && !is_pfx;
    assign deq       = out_valid && out_ready && !flush;

    // Exceptions must report the prefix address, so a merged entry takes pfx_pc.
    always_comb begin
        merged.pc   = pfx_valid ? pfx_pc   : in_pc;
        merged.pfx  = pfx_valid ? pfx_word : NOP_INSN;
        merged.insn = in_insn;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pfx_valid <= 1'b0;
            pfx_word  <= '0;
            pfx_pc    <= '0;
        end else if (flush) begin
            pfx_valid <= 1'b0;
        end else if (accept && is_pfx) begin
            pfx_valid <= 1'b1;
            pfx_word  <= in_insn;
            pfx_pc    <= in_pc;
        end else if (enq) begin
            pfx_valid <= 1'b0;
        end
    end

    rfphoenix_ifb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .wr_en  (enq),
        .wr_dat (merged),
        .rd_en  (deq),
        .rd_dat (out_ifb),
        .count  (count)
    );

endmodule

// File: tb/tb_rfphoenix_ifb_queue.sv
// Bench for rfphoenix_ifb_queue: directed scenarios plus a randomized run,
// all scored against a queue-based model of the fetch buffer.
module tb_rfphoenix_ifb_queue;
    import rfPhoenixPkg::*;

    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_pc;
    Instruction         in_insn;
    logic               out_valid;
    logic               out_ready;
    InstructionFetchbuf out_ifb;
    logic [2:0]         count;

    int total = 0;
    int bad   = 0;

    InstructionFetchbuf q[$];
    logic               m_pv;
    Instruction         m_pw;
    logic [31:0]        m_pp;
    logic [31:0]        pop_pc[$];
    Instruction         tb_nop;

    always #5 clk = ~clk;

    rfphoenix_ifb_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_insn   (in_insn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ifb   (out_ifb),
        .count     (count)
    );

    function automatic Instruction mk(input logic [5:0] op, input logic [15:0] imm);
        Instruction r;
        r.imm    = imm;
        r.rb     = 5'($urandom_range(0, 31));
        r.rt     = 5'($urandom_range(0, 31));
        r.opcode = op;
        return r;
    endfunction

    task automatic model_clear();
        q.delete();
        pop_pc.delete();
        m_pv = 1'b0;
        m_pw = '0;
        m_pp = '0;
    endtask

    // Drives one cycle from a negedge, advances the model, returns at the next negedge.
    task automatic drive_cycle(input logic v, input Instruction insn, input logic [31:0] pc,
                               input logic ordy, input logic fl);
        InstructionFetchbuf e;
        logic acc;
        logic pop;
        in_valid  = v;
        in_insn   = insn;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        acc = v && (q.size() < DEPTH) && !fl;
        pop = (q.size() > 0) && ordy && !fl;
        if (fl) begin
            q.delete();
            m_pv = 1'b0;
        end else begin
            if (pop) begin
                pop_pc.push_back(q[0].pc);
                void'(q.pop_front());
            end
            if (acc) begin
                if (insn.opcode == PFX) begin
                    m_pv = 1'b1;
                    m_pw = insn;
                    m_pp = pc;
                end else begin
                    e.pc   = m_pv ? m_pp : pc;
                    e.pfx  = m_pv ? m_pw : tb_nop;
                    e.insn = insn;
                    q.push_back(e);
                    m_pv = 1'b0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 32'h0, ordy, 1'b0);
    endtask

    task automatic test_reset();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0) begin
            bad++;
            $display("FAIL reset_ctrl: got out_valid=%b in_ready=%b count=%0d want 0 1 0",
                     out_valid, in_ready, count);
        end
        total++;
        if (out_ifb !== '0) begin
            bad++;
            $display("FAIL reset_ifb: got %h want 0", out_ifb);
        end
    endtask

    task automatic test_single();
        drive_cycle(1'b1, mk(ADDI, 16'h0042), 32'h100, 1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || count !== 3'd1 || out_ifb.pc !== 32'h100 || out_ifb.pfx !== tb_nop) begin
            bad++;
            $display("FAIL single: got v=%b cnt=%0d pc=%h pfx=%h want 1 1 100 %h",
                     out_valid, count, out_ifb.pc, out_ifb.pfx, tb_nop);
        end
        drive_cycle(1'b0, '0, 32'h0, 1'b1, 1'b0);
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drain: got cnt=%0d v=%b want 0 0", count, out_valid);
        end
    endtask

    task automatic test_prefix_merge();
        Instruction a;
        a = mk(ADDI, 16'h0010);
        drive_cycle(1'b1, mk(PFX, 16'hABCD), 32'h200, 1'b0, 1'b0);
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL pfx_held: got cnt=%0d v=%b want 0 0", count, out_valid);
        end
        drive_cycle(1'b1, a, 32'h205, 1'b0, 1'b0);
        total++;
        if (count !== 3'd1 || out_ifb.pc !== 32'h200 || out_ifb.insn !== a ||
            {out_ifb.pfx.imm, out_ifb.insn.imm} !== 32'hABCD0010) begin
            bad++;
            $display("FAIL pfx_merge: got cnt=%0d pc=%h imm=%h want 1 200 abcd0010",
                     count, out_ifb.pc, {out_ifb.pfx.imm, out_ifb.insn.imm});
        end
        idle(1, 1'b1);
    endtask

    task automatic test_double_prefix();
        drive_cycle(1'b1, mk(PFX, 16'h1111), 32'h300, 1'b0, 1'b0);
        drive_cycle(1'b1, mk(PFX, 16'h2222), 32'h305, 1'b0, 1'b0);
        drive_cycle(1'b1, mk(ORI, 16'h0003), 32'h30A, 1'b0, 1'b0);
        total++;
        if (count !== 3'd1 || out_ifb.pfx.imm !== 16'h2222 || out_ifb.pc !== 32'h305 ||
            out_ifb.insn.opcode !== ORI) begin
            bad++;
            $display("FAIL double_pfx: got cnt=%0d imm=%h pc=%h op=%h want 1 2222 305 %h",
                     count, out_ifb.pfx.imm, out_ifb.pc, out_ifb.insn.opcode, ORI);
        end
        idle(1, 1'b1);
    endtask

    task automatic test_full();
        int k = 0;
        int cyc = 0;
        pop_pc.delete();
        for (int c = 0; c < 8; c++) begin
            if (k < 6) begin
                if (q.size() < DEPTH) k++;
                drive_cycle(1'b1, mk(ADDI, 16'(k - 1)), 32'h1000 + 32'(k - 1) * 4, 1'b0, 1'b0);
            end
        end
        total++;
        if (count !== 3'd4 || in_ready !== 1'b0 || k !== 4) begin
            bad++;
            $display("FAIL full: got cnt=%0d in_ready=%b accepted=%0d want 4 0 4", count, in_ready, k);
        end
        while ((k < 6 || q.size() > 0) && cyc < 40) begin
            if (k < 6) begin
                if (q.size() < DEPTH) k++;
                drive_cycle(1'b1, mk(ADDI, 16'(k - 1)), 32'h1000 + 32'(k - 1) * 4, 1'b1, 1'b0);
            end else begin
                drive_cycle(1'b0, '0, 32'h0, 1'b1, 1'b0);
            end
            cyc++;
            total++;
            if (count !== 3'(q.size()) || in_ready !== (q.size() < DEPTH)) begin
                bad++;
                $display("FAIL full_drain_cnt: got cnt=%0d rdy=%b want %0d %b",
                         count, in_ready, q.size(), q.size() < DEPTH);
            end
        end
        total++;
        if (pop_pc.size() != 6) begin
            bad++;
            $display("FAIL full_order_len: got %0d entries want 6", pop_pc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (pop_pc[i] !== 32'h1000 + 32'(i) * 4) begin
                    bad++;
                    $display("FAIL full_order: got pc=%h want %h", pop_pc[i], 32'h1000 + 32'(i) * 4);
                end
            end
        end
    endtask

    task automatic test_stream();
        int n = 0;
        int cyc = 0;
        pop_pc.delete();
        while ((n < 20 || q.size() > 0) && cyc < 60) begin
            if (n < 20) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL stream_rdy: got in_ready=%b want 1", in_ready);
                end
                drive_cycle(1'b1, mk(ADDI, 16'(n)), 32'h2000 + 32'(n), 1'b1, 1'b0);
                n++;
            end else begin
                drive_cycle(1'b0, '0, 32'h0, 1'b1, 1'b0);
            end
            cyc++;
            if (q.size() > 0) begin
                total++;
                if (out_valid !== 1'b1 || out_ifb !== q[0]) begin
                    bad++;
                    $display("FAIL stream_head: got v=%b %h want 1 %h", out_valid, out_ifb, q[0]);
                end
            end
        end
        total++;
        if (pop_pc.size() != 20 || pop_pc[19] !== 32'h2013) begin
            bad++;
            $display("FAIL stream_count: got %0d entries want 20", pop_pc.size());
        end
    endtask

    task automatic test_flush();
        Instruction a;
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, mk(ADDI, 16'(i)), 32'h400 + 32'(i), 1'b0, 1'b0);
        drive_cycle(1'b1, mk(PFX, 16'h5555), 32'h410, 1'b0, 1'b0);
        drive_cycle(1'b1, mk(ADDI, 16'h0077), 32'h420, 1'b0, 1'b1);
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush: got cnt=%0d v=%b rdy=%b want 0 0 1", count, out_valid, in_ready);
        end
        a = mk(ADDI, 16'h0088);
        drive_cycle(1'b1, a, 32'h430, 1'b0, 1'b0);
        total++;
        if (count !== 3'd1 || out_ifb.pfx !== tb_nop || out_ifb.pc !== 32'h430 || out_ifb.insn !== a) begin
            bad++;
            $display("FAIL flush_pfx_drop: got cnt=%0d pfx=%h pc=%h want 1 %h 430",
                     count, out_ifb.pfx, out_ifb.pc, tb_nop);
        end
        idle(1, 1'b1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) drive_cycle(1'b1, mk(ORI, 16'(i)), 32'h500 + 32'(i), 1'b0, 1'b0);
        drive_cycle(1'b1, mk(PFX, 16'h9999), 32'h510, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_clear();
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: got cnt=%0d v=%b rdy=%b want 0 0 1", count, out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_cycle(1'b1, mk(ADDI, 16'h0001), 32'h520, 1'b0, 1'b0);
        total++;
        if (count !== 3'd1 || out_ifb.pc !== 32'h520 || out_ifb.pfx !== tb_nop) begin
            bad++;
            $display("FAIL post_reset_accept: got cnt=%0d pc=%h want 1 520", count, out_ifb.pc);
        end
        idle(1, 1'b1);
    endtask

    task automatic test_random();
        Instruction w;
        logic       v;
        logic       fl;
        for (int c = 0; c < 400; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 39) == 0);
            w  = ($urandom_range(0, 4) == 0) ? mk(PFX, 16'($urandom))
                                             : mk(6'($urandom_range(0, 62)), 16'($urandom));
            drive_cycle(v, w, $urandom, ($urandom_range(0, 2) != 0), fl);
            total++;
            if (count !== 3'(q.size()) || out_valid !== (q.size() > 0) || in_ready !== (q.size() < DEPTH)) begin
                bad++;
                $display("FAIL rand_ctrl: cycle %0d got cnt=%0d v=%b rdy=%b want %0d", c,
                         count, out_valid, in_ready, q.size());
            end
            if (q.size() > 0) begin
                total++;
                if (out_ifb !== q[0]) begin
                    bad++;
                    $display("FAIL rand_head: cycle %0d got %h want %h", c, out_ifb, q[0]);
                end
            end
        end
        idle(6, 1'b1);
    endtask

    initial begin
        tb_nop    = '0;
        tb_nop.opcode = 6'h00;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_insn   = '0;
        out_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_single();
        test_prefix_merge();
        test_double_prefix();
        test_full();
        test_stream();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
